// File: rtl/freelist_alloc_2w.sv
// freelist_alloc_2w: dual-lane preg allocator feeding rename, merging flush returns with commit releases
// into the free-list write port; defining ALLOC_STATS_EN adds stall_cnt_o/alloc_cnt_o counters.
module freelist_alloc_2w #(
  parameter int PREG_WIDTH   = 5,
  parameter int FL_NUM_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ALLOC_STATS_EN
  output logic [31:0]             stall_cnt_o,
  output logic [31:0]             alloc_cnt_o,
`endif
  input  logic                    req_first_valid_i,
  input  logic                    req_second_valid_i,
  output logic                    req_ready_o,
  input  logic [FL_NUM_WIDTH-1:0] fl_num_i,
  output logic                    fl_rd_first_en_o,
  output logic                    fl_rd_second_en_o,
  input  logic [PREG_WIDTH-1:0]   fl_rdata_first_i,
  input  logic [PREG_WIDTH-1:0]   fl_rdata_second_i,
  output logic                    alloc_first_valid_o,
  output logic                    alloc_second_valid_o,
  output logic [PREG_WIDTH-1:0]   alloc_first_preg_o,
  output logic [PREG_WIDTH-1:0]   alloc_second_preg_o,
  input  logic                    alloc_ready_i,
  input  logic                    commit_first_en_i,
  input  logic                    commit_second_en_i,
  input  logic [PREG_WIDTH-1:0]   commit_first_preg_i,
  input  logic [PREG_WIDTH-1:0]   commit_second_preg_i,
  output logic                    commit_ready_o,
  input  logic                    flush_i,
  output logic                    fl_wr_first_en_o,
  output logic                    fl_wr_second_en_o,
  output logic [PREG_WIDTH-1:0]   fl_wdata_first_o,
  output logic [PREG_WIDTH-1:0]   fl_wdata_second_o
);
  logic [1:0] need;
  logic hold, accept, ret_pending, ret_load;
  logic ret_first_en, ret_second_en;
  logic [PREG_WIDTH-1:0] ret_first_preg, ret_second_preg;
  assign need = {1'b0, req_first_valid_i} + {1'b0, req_second_valid_i};
  assign hold = alloc_first_valid_o | alloc_second_valid_o;
  // whole pair or nothing, so rename stays in order
  assign accept = !flush_i && !ret_pending && (!hold || alloc_ready_i)
                  && (fl_num_i >= FL_NUM_WIDTH'(need));
  assign ret_load = flush_i && hold && !alloc_ready_i;
  assign req_ready_o = accept;
  assign fl_rd_first_en_o = accept & req_first_valid_i;
  assign fl_rd_second_en_o = accept & req_second_valid_i;
  assign commit_ready_o = !ret_pending;
  // a lone tag, returned or committed, always rides the first write port
  assign fl_wr_first_en_o = ret_pending ? ret_first_en : (commit_first_en_i | commit_second_en_i);
  assign fl_wr_second_en_o = ret_pending ? ret_second_en : (commit_first_en_i & commit_second_en_i);
  assign fl_wdata_first_o = ret_pending ? ret_first_preg
                          : (commit_first_en_i ? commit_first_preg_i : commit_second_preg_i);
  assign fl_wdata_second_o = ret_pending ? ret_second_preg : commit_second_preg_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_first_valid_o <= 1'b0;
      alloc_second_valid_o <= 1'b0;
      alloc_first_preg_o <= '0;
      alloc_second_preg_o <= '0;
      ret_pending <= 1'b0;
      ret_first_en <= 1'b0;
      ret_second_en <= 1'b0;
      ret_first_preg <= '0;
      ret_second_preg <= '0;
    end else begin
      ret_pending <= ret_load;
      if (ret_load) begin
        ret_first_en <= 1'b1;
        ret_second_en <= alloc_first_valid_o & alloc_second_valid_o;
        ret_first_preg <= alloc_first_valid_o ? alloc_first_preg_o : alloc_second_preg_o;
        ret_second_preg <= alloc_second_preg_o;
      end
      if (accept) begin
        alloc_first_valid_o <= req_first_valid_i;
        alloc_second_valid_o <= req_second_valid_i;
        alloc_first_preg_o <= req_first_valid_i ? fl_rdata_first_i : '0;
        alloc_second_preg_o <= req_second_valid_i ? fl_rdata_second_i : '0;
      end else if (hold && (alloc_ready_i || flush_i)) begin
        alloc_first_valid_o <= 1'b0;
        alloc_second_valid_o <= 1'b0;
      end
    end
  end
`ifdef ALLOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      alloc_cnt_o <= '0;
    end else begin
      if (need != 2'd0 && !accept && !flush_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (accept) alloc_cnt_o <= alloc_cnt_o + 32'(need);
    end
  end
`endif
endmodule

// File: tb/tb_freelist_alloc_2w.sv
// tb_freelist_alloc_2w: scoreboard bench for freelist_alloc_2w; expected allocations are queued
// when a request is driven and popped one edge later when the output register should show them.
module tb_freelist_alloc_2w;
  localparam int PW = 5;
  localparam int NW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_first, req_second, req_ready;
  logic [NW-1:0] fl_num;
  logic rd_first, rd_second;
  logic [PW-1:0] rdata_first, rdata_second;
  logic af_v, as_v;
  logic [PW-1:0] af_p, as_p;
  logic alloc_ready;
  logic c_first, c_second;
  logic [PW-1:0] c_first_p, c_second_p;
  logic commit_ready, flush;
  logic wr_first, wr_second;
  logic [PW-1:0] wd_first, wd_second;
`ifdef ALLOC_STATS_EN
  logic [31:0] stall_cnt, alloc_cnt;
`endif
  int checks = 0;
  int failures = 0;
  logic [2*PW+1:0] sbq[$];
  logic [2*PW+1:0] e;

  freelist_alloc_2w #(.PREG_WIDTH(PW), .FL_NUM_WIDTH(NW)) dut (
    .clk(clk), .rst(rst),
`ifdef ALLOC_STATS_EN
    .stall_cnt_o(stall_cnt), .alloc_cnt_o(alloc_cnt),
`endif
    .req_first_valid_i(req_first), .req_second_valid_i(req_second), .req_ready_o(req_ready),
    .fl_num_i(fl_num), .fl_rd_first_en_o(rd_first), .fl_rd_second_en_o(rd_second),
    .fl_rdata_first_i(rdata_first), .fl_rdata_second_i(rdata_second),
    .alloc_first_valid_o(af_v), .alloc_second_valid_o(as_v),
    .alloc_first_preg_o(af_p), .alloc_second_preg_o(as_p), .alloc_ready_i(alloc_ready),
    .commit_first_en_i(c_first), .commit_second_en_i(c_second),
    .commit_first_preg_i(c_first_p), .commit_second_preg_i(c_second_p),
    .commit_ready_o(commit_ready), .flush_i(flush),
    .fl_wr_first_en_o(wr_first), .fl_wr_second_en_o(wr_second),
    .fl_wdata_first_o(wd_first), .fl_wdata_second_o(wd_second)
  );

  always #5 clk = ~clk;

  // pregs of invalid lanes are don't-care, so they are masked to zero
  function automatic logic [2*PW+1:0] got();
    return {af_v, as_v, af_v ? af_p : {PW{1'b0}}, as_v ? as_p : {PW{1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_first = 0; req_second = 0; flush = 0; alloc_ready = 1; fl_num = 6'd32;
    c_first = 0; c_second = 0; c_first_p = 0; c_second_p = 0;
    rdata_first = 0; rdata_second = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (3) tick();
    checks++;
    if ({af_v, as_v, af_p, as_p} !== '0) begin
      failures++; $display("FAIL reset_alloc got=%h exp=0", {af_v, as_v, af_p, as_p});
    end
    checks++;
    if ({commit_ready, wr_first, wr_second} !== 3'b100) begin
      failures++; $display("FAIL reset_wr got=%b exp=100", {commit_ready, wr_first, wr_second});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_pair();
    req_first = 1; req_second = 1; rdata_first = 3; rdata_second = 4;
    #1;
    checks++;
    if ({rd_first, rd_second, req_ready} !== 3'b111) begin
      failures++; $display("FAIL pair_pop got=%b exp=111", {rd_first, rd_second, req_ready});
    end
    sbq.push_back({1'b1, 1'b1, 5'd3, 5'd4});
    tick();
    req_first = 0; req_second = 0;
    e = sbq.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL pair_alloc got=%h exp=%h", got(), e); end
  endtask

  task automatic test_second_only();
    req_second = 1; rdata_first = 1; rdata_second = 9;
    #1;
    checks++;
    if ({rd_first, rd_second} !== 2'b01) begin
      failures++; $display("FAIL second_pop got=%b exp=01", {rd_first, rd_second});
    end
    sbq.push_back({1'b0, 1'b1, 5'd0, 5'd9});
    tick();
    req_second = 0;
    e = sbq.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL second_alloc got=%h exp=%h", got(), e); end
  endtask

  task automatic test_insufficient();
    tick();
    fl_num = 1; req_first = 1; req_second = 1; rdata_first = 12; rdata_second = 13;
    #1;
    checks++;
    if ({req_ready, rd_first, rd_second} !== 3'b000) begin
      failures++; $display("FAIL short_pair got=%b exp=000", {req_ready, rd_first, rd_second});
    end
    sbq.push_back('0);
    tick();
    e = sbq.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL short_hold got=%h exp=%h", got(), e); end
    fl_num = 0; req_second = 0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL empty_single got=%b exp=0", req_ready); end
    fl_num = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL one_single got=%b exp=1", req_ready); end
    sbq.push_back({1'b1, 1'b0, 5'd12, 5'd0});
    tick();
    e = sbq.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL one_alloc got=%h exp=%h", got(), e); end
    fl_num = 2; req_second = 1; rdata_first = 14; rdata_second = 15;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL two_pair got=%b exp=1", req_ready); end
    sbq.push_back({1'b1, 1'b1, 5'd14, 5'd15});
    tick();
    idle();
    e = sbq.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL two_alloc got=%h exp=%h", got(), e); end
  endtask

  task automatic test_hold();
    req_first = 1; req_second = 1; rdata_first = 5; rdata_second = 6;
    tick();
    alloc_ready = 0; rdata_first = 1; rdata_second = 2;
    repeat (3) begin
      #1;
      checks++;
      if ({req_ready, rd_first, rd_second} !== 3'b000) begin
        failures++; $display("FAIL hold_pop got=%b exp=000", {req_ready, rd_first, rd_second});
      end
      sbq.push_back({1'b1, 1'b1, 5'd5, 5'd6});
      tick();
      e = sbq.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL hold_keep got=%h exp=%h", got(), e); end
    end
    alloc_ready = 1; rdata_first = 10; rdata_second = 11;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reload_ready got=%b exp=1", req_ready); end
    sbq.push_back({1'b1, 1'b1, 5'd10, 5'd11});
    tick();
    idle();
    e = sbq.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL reload_alloc got=%h exp=%h", got(), e); end
  endtask

  task automatic test_flush_return();
    req_first = 1; req_second = 1; rdata_first = 5; rdata_second = 6;
    tick();
    req_first = 0; req_second = 0; alloc_ready = 0; flush = 1;
    c_first = 1; c_second = 1; c_first_p = 20; c_second_p = 21;
    #1;
    checks++;
    if ({commit_ready, req_ready, wr_first, wr_second, wd_first, wd_second} !== {4'b1011, 5'd20, 5'd21}) begin
      failures++; $display("FAIL flush_commit got=%b", {commit_ready, req_ready, wr_first, wr_second, wd_first, wd_second});
    end
    tick();
    flush = 0; alloc_ready = 1; req_first = 1; req_second = 1;
    #1;
    checks++;
    if ({commit_ready, req_ready, wr_first, wr_second, wd_first, wd_second} !== {4'b0011, 5'd5, 5'd6}) begin
      failures++; $display("FAIL return_pair got=%b", {commit_ready, req_ready, wr_first, wr_second, wd_first, wd_second});
    end
    checks++;
    if (got() !== '0) begin failures++; $display("FAIL return_clear got=%h exp=0", got()); end
    req_first = 0; req_second = 0;
    tick();
    checks++;
    if ({commit_ready, wr_first, wr_second, wd_first, wd_second} !== {3'b111, 5'd20, 5'd21}) begin
      failures++; $display("FAIL after_return got=%b", {commit_ready, wr_first, wr_second, wd_first, wd_second});
    end
    idle();
    tick();
  endtask

  task automatic test_flush_lane1();
    req_second = 1; rdata_second = 7;
    tick();
    req_second = 0; alloc_ready = 0; flush = 1;
    tick();
    #1;
    checks++;
    if ({commit_ready, wr_first, wr_second, wd_first} !== {3'b010, 5'd7}) begin
      failures++; $display("FAIL return_single got=%b exp=0107", {commit_ready, wr_first, wr_second, wd_first});
    end
    tick();
    flush = 0;
    #1;
    checks++;
    if ({commit_ready, wr_first, wr_second} !== 3'b100) begin
      failures++; $display("FAIL double_flush got=%b exp=100", {commit_ready, wr_first, wr_second});
    end
    idle();
    tick();
  endtask

  task automatic test_flush_consumed();
    req_first = 1; req_second = 1; rdata_first = 5; rdata_second = 6;
    tick();
    req_first = 0; req_second = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    checks++;
    if ({commit_ready, wr_first, wr_second} !== 3'b100 || got() !== '0) begin
      failures++; $display("FAIL flush_consumed got=%b alloc=%h exp=100", {commit_ready, wr_first, wr_second}, got());
    end
    c_second = 1; c_second_p = 13;
    #1;
    checks++;
    if ({wr_first, wr_second, wd_first} !== {2'b10, 5'd13}) begin
      failures++; $display("FAIL commit_steer got=%b exp=1001101", {wr_first, wr_second, wd_first});
    end
    idle();
    tick();
  endtask

`ifdef ALLOC_STATS_EN
  task automatic test_stats();
    logic [31:0] s0, a0;
    s0 = stall_cnt; a0 = alloc_cnt;
    fl_num = 0; req_first = 1; req_second = 1;
    repeat (3) tick();
    fl_num = 32;
    tick();
    req_second = 0;
    tick();
    flush = 1; req_second = 1;
    tick();
    idle();
    checks++;
    if (stall_cnt - s0 !== 32'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt - s0); end
    checks++;
    if (alloc_cnt - a0 !== 32'd3) begin failures++; $display("FAIL alloc_cnt got=%0d exp=3", alloc_cnt - a0); end
    tick();
  endtask
`endif

  task automatic test_async_reset();
    req_first = 1; req_second = 1; rdata_first = 5; rdata_second = 6;
    tick();
    idle(); alloc_ready = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({af_v, as_v} !== 2'b00) begin failures++; $display("FAIL async_reset got=%b exp=00", {af_v, as_v}); end
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_pair();
    test_second_only();
    test_insufficient();
    test_hold();
    test_flush_return();
    test_flush_lane1();
    test_flush_consumed();
`ifdef ALLOC_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
